sram_ctrl: RTL and testbench

//  Memory-side responder for the MEM-stage data port (ce/we/addr/sel/data). Turns each

---
 rtl/sram_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Multi-cycle bridge from the single-cycle MEM-stage data port to an asynchronous 32-bit SRAM.
// Stall: read = WAIT_CYCLES+1 cycles, write = WAIT_CYCLES+2 cycles; new requests accepted only in IDLE.
module sram_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [31:0]       ram_data_i,
  output logic [31:0]       ram_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, WHOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    stallreq_o  = 1'b0;
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_be_n_o = 4'hF;
    sram_dq_oe  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ram_ce_i) begin
          stallreq_o = 1'b1;
          addr_d     = ram_addr_i[ADDR_W+1:2];
          sel_d      = ram_sel_i;
          wdata_d    = ram_data_i;
          cnt_d      = WAIT_CYCLES[3:0];
          state_d    = ram_we_i ? WRITE : READ;
        end
      end
      READ: begin
        stallreq_o  = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = 4'h0;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = sram_dq_i;
          state_d = DONE;
        end
      end
      WRITE: begin
        stallreq_o  = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_we_n_o = 1'b0;
        sram_be_n_o = ~sel_q;
        sram_dq_oe  = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = WHOLD;
      end
      WHOLD: begin
        // Strobe released but address/data still driven for SRAM hold time.
        stallreq_o  = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_be_n_o = ~sel_q;
        sram_dq_oe  = 1'b1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rst) stallreq_o = 1'b0;
  end

  assign sram_addr_o = addr_q;
  assign sram_dq_o   = wdata_q;
  assign ram_data_o  = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYCLES 2, 1, 15) each with a behavioural async SRAM,
// checked against a word-array reference model and the stall/strobe lengths derived from WAIT_CYCLES.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce[3], we[3], stall[3], ce_n[3], oe_n[3], we_n[3], dq_oe[3];
  logic [31:0] addr_in[3], wdat[3], rdat[3], dq_o[3], dq_i[3];
  logic [3:0]  sel[3], be_n[3];
  logic [19:0] s_addr[3];
  logic [31:0] mem[3][256];
  logic [31:0] ref_mem[3][256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .clk(clk), .rst(rst),
      .ram_ce_i(ce[g]), .ram_we_i(we[g]), .ram_addr_i(addr_in[g]),
      .ram_sel_i(sel[g]), .ram_data_i(wdat[g]), .ram_data_o(rdat[g]),
      .stallreq_o(stall[g]), .sram_addr_o(s_addr[g]), .sram_be_n_o(be_n[g]),
      .sram_ce_n_o(ce_n[g]), .sram_oe_n_o(oe_n[g]), .sram_we_n_o(we_n[g]),
      .sram_dq_o(dq_o[g]), .sram_dq_oe(dq_oe[g]), .sram_dq_i(dq_i[g])
    );

    assign dq_i[g] = (!ce_n[g] && !oe_n[g]) ? mem[g][s_addr[g][7:0]] : 32'h0;

    always @(posedge clk) begin
      if (!ce_n[g] && !we_n[g] && dq_oe[g])
        for (int b = 0; b < 4; b++)
          if (!be_n[g][b]) mem[g][s_addr[g][7:0]][8*b +: 8] = dq_o[g][8*b +: 8];
    end
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Issue one request and observe it until stallreq_o drops (returns in the DONE cycle).
  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit scramble,
                        output int st, output int oe_c, output int we_c, output int dqoe_c,
                        output logic [31:0] rd, output logic [19:0] a_seen,
                        output logic [3:0] be_seen, output bit stable, output bit timeout,
                        output logic [3:0] done_strobes);
    logic [31:0] d_seen;
    bit first;
    int n;
    st = 0; oe_c = 0; we_c = 0; dqoe_c = 0; stable = 1; first = 1; n = 0;
    a_seen = '0; be_seen = 4'hF; d_seen = '0;
    @(negedge clk);
    ce[k] = 1'b1; we[k] = w; addr_in[k] = a; sel[k] = s; wdat[k] = d;
    #1;
    while (stall[k] && n < 40) begin
      st++;
      if (!oe_n[k]) oe_c++;
      if (!we_n[k]) we_c++;
      if (dq_oe[k]) dqoe_c++;
      if (!ce_n[k]) begin
        if (first) begin
          a_seen = s_addr[k]; be_seen = be_n[k]; d_seen = dq_o[k]; first = 0;
        end else if (s_addr[k] !== a_seen || be_n[k] !== be_seen || dq_o[k] !== d_seen) begin
          stable = 0;
        end
      end
      @(negedge clk);
      if (scramble) begin
        ce[k] = 1'($urandom); we[k] = 1'($urandom); addr_in[k] = $urandom;
        sel[k] = 4'($urandom); wdat[k] = $urandom;
      end else begin
        ce[k] = 1'b0;
      end
      #1;
      n++;
    end
    timeout = (n >= 40);
    done_strobes = {ce_n[k], oe_n[k], we_n[k], dq_oe[k]};
    ce[k] = 1'b0;
    rd = rdat[k];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ce[0] = 1'b1;
    #1;
    checks++;
    if (stall[0] !== 1'b0) begin errors++; $display("FAIL reset_stall_forced: got %b want 0", stall[0]); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ce_n[k], oe_n[k], we_n[k], be_n[k], dq_oe[k]} !== 8'b1111_1110) begin
        errors++; $display("FAIL reset_strobes[%0d]: got %b want 11111110", k,
                           {ce_n[k], oe_n[k], we_n[k], be_n[k], dq_oe[k]});
      end
      checks++;
      if (s_addr[k] !== 20'd0 || dq_o[k] !== 32'd0 || rdat[k] !== 32'd0) begin
        errors++; $display("FAIL reset_regs[%0d]: addr=%h dq=%h rd=%h want 0", k, s_addr[k], dq_o[k], rdat[k]);
      end
    end
    ce[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    int st, oc, wc, dc; logic [31:0] rd; logic [19:0] as; logic [3:0] bs, ds; bit stb, to;
    access(0, 1'b0, 32'h80, 4'hF, 32'h0, 0, st, oc, wc, dc, rd, as, bs, stb, to, ds);
    checks++; if (to || st != 3) begin errors++; $display("FAIL read_stall: got %0d want 3", st); end
    checks++; if (oc != 2) begin errors++; $display("FAIL read_oe_len: got %0d want 2", oc); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL read_data: got %h want 12345678", rd); end
    checks++; if (as !== 20'h20 || bs !== 4'h0) begin errors++; $display("FAIL read_addr_be: got %h/%b want 20/0000", as, bs); end
    checks++; if (ds !== 4'b1110) begin errors++; $display("FAIL read_done_strobes: got %b want 1110", ds); end
  endtask

  task automatic test_write_byte();
    int st, oc, wc, dc; logic [31:0] rd; logic [19:0] as; logic [3:0] bs, ds; bit stb, to;
    access(0, 1'b1, 32'h81, 4'b0010, 32'hAAAAAAAA, 0, st, oc, wc, dc, rd, as, bs, stb, to, ds);
    checks++; if (as !== 20'h20) begin errors++; $display("FAIL sb_addr: got %h want 20", as); end
    checks++; if (bs !== 4'b1101) begin errors++; $display("FAIL sb_be_n: got %b want 1101", bs); end
    checks++; if (wc != 2) begin errors++; $display("FAIL sb_we_len: got %0d want 2", wc); end
    checks++; if (dc != 3) begin errors++; $display("FAIL sb_dqoe_len: got %0d want 3", dc); end
    checks++; if (to || st != 4) begin errors++; $display("FAIL sb_stall: got %0d want 4", st); end
    ref_mem[0][8'h20][15:8] = 8'hAA;
    access(0, 1'b0, 32'h80, 4'hF, 32'h0, 0, st, oc, wc, dc, rd, as, bs, stb, to, ds);
    checks++; if (rd !== 32'h1234AA78) begin errors++; $display("FAIL sb_readback: got %h want 1234aa78", rd); end
  endtask

  task automatic test_back_to_back();
    int st, oc, wc, dc; logic [31:0] rd; logic [19:0] as; logic [3:0] bs, ds; bit stb, to;
    access(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 0, st, oc, wc, dc, rd, as, bs, stb, to, ds);
    ref_mem[0][8'h40] = 32'hDEADBEEF;
    access(0, 1'b0, 32'h100, 4'hF, 32'h0, 0, st, oc, wc, dc, rd, as, bs, stb, to, ds);
    checks++; if (to || st != 3) begin errors++; $display("FAIL b2b_read_stall: got %0d want 3", st); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_read_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid_write();
    int st, oc, wc, dc; logic [31:0] rd; logic [19:0] as; logic [3:0] bs, ds; bit stb, to;
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr_in[0] = 32'h3C0; sel[0] = 4'hF; wdat[0] = 32'h5A5A5A5A;
    @(negedge clk); ce[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (stall[0] !== 1'b0 || we_n[0] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_write_during: stall=%b we_n=%b want 0/0", stall[0], we_n[0]);
    end
    @(negedge clk);
    checks++;
    if ({ce_n[0], oe_n[0], we_n[0], dq_oe[0], stall[0]} !== 5'b11100) begin
      errors++; $display("FAIL rst_mid_write_after: got %b want 11100", {ce_n[0], oe_n[0], we_n[0], dq_oe[0], stall[0]});
    end
    rst = 1'b0;
    access(0, 1'b0, 32'h40, 4'hF, 32'h0, 0, st, oc, wc, dc, rd, as, bs, stb, to, ds);
    checks++; if (to || st != 3 || rd !== ref_mem[0][8'h10]) begin
      errors++; $display("FAIL rst_then_read: stall=%0d data=%h want 3/%h", st, rd, ref_mem[0][8'h10]);
    end
  endtask

  task automatic test_mid_access_change();
    int st, oc, wc, dc; logic [31:0] rd; logic [19:0] as; logic [3:0] bs, ds; bit stb, to;
    access(0, 1'b0, 32'h84, 4'hF, 32'h0, 1, st, oc, wc, dc, rd, as, bs, stb, to, ds);
    checks++; if (as !== 20'h21 || !stb) begin errors++; $display("FAIL mid_change_addr: got %h stable=%0d want 21/1", as, stb); end
    checks++; if (to || st != 3 || rd !== ref_mem[0][8'h21]) begin
      errors++; $display("FAIL mid_change_data: stall=%0d data=%h want 3/%h", st, rd, ref_mem[0][8'h21]);
    end
  endtask

  // Random traffic on all three WAIT_CYCLES settings against the word-array reference.
  task automatic test_random(input int nops);
    int st, oc, wc, dc, wt, word; logic [31:0] rd, a, d; logic [19:0] as; logic [3:0] bs, ds, s;
    bit stb, to, w, scr;
    for (int k = 0; k < 3; k++) begin
      wt = wait_of(k);
      for (int i = 0; i < nops; i++) begin
        w = 1'($urandom); word = $urandom_range(0, 127); s = 4'($urandom); d = $urandom;
        scr = ($urandom_range(0, 3) == 0);
        a = (32'($urandom_range(0, 1023)) << 22) | (32'(word) << 2) | 32'($urandom_range(0, 3));
        access(k, w, a, s, d, scr, st, oc, wc, dc, rd, as, bs, stb, to, ds);
        checks++;
        if (to || st != wt + (w ? 2 : 1)) begin
          errors++; $display("FAIL rnd_stall[%0d] w=%0d: got %0d want %0d", k, w, st, wt + (w ? 2 : 1));
        end
        checks++;
        if (oc != (w ? 0 : wt) || wc != (w ? wt : 0) || dc != (w ? wt + 1 : 0)) begin
          errors++; $display("FAIL rnd_strobes[%0d] w=%0d: oe=%0d we=%0d dqoe=%0d", k, w, oc, wc, dc);
        end
        checks++;
        if (as !== 20'(word) || bs !== (w ? ~s : 4'h0) || !stb) begin
          errors++; $display("FAIL rnd_addr_be[%0d]: addr=%h be_n=%b stable=%0d want %h/%b/1",
                             k, as, bs, stb, word, w ? ~s : 4'h0);
        end
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) ref_mem[k][word][8*b +: 8] = d[8*b +: 8];
        end else begin
          checks++;
          if (rd !== ref_mem[k][word]) begin
            errors++; $display("FAIL rnd_read[%0d] word %0d: got %h want %h", k, word, rd, ref_mem[k][word]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ce[k] = 1'b0; we[k] = 1'b0; addr_in[k] = '0; sel[k] = '0; wdat[k] = '0;
      for (int i = 0; i < 256; i++) begin
        mem[k][i] = 32'(i) * 32'h9E3779B1 + 32'(k);
        ref_mem[k][i] = 32'(i) * 32'h9E3779B1 + 32'(k);
      end
    end
    mem[0][8'h20] = 32'h12345678;
    ref_mem[0][8'h20] = 32'h12345678;
    test_reset();
    test_read();
    test_write_byte();
    test_back_to_back();
    test_reset_mid_write();
    test_mid_access_change();
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
